htg9200_rst_sequencer: RTL and testbench
========================================

// Module: htg9200_rst_sequencer
// PURPOSE
//  Consumes the board-infrastructure reset/ready outputs in the user_clk domain and releases N staged
//  resets (e.g. IO/ADC -> DSP -> packetiser -> SW regs) in order, with a fixed gap between stages.
//  Re-asserts all stages on loss of IDELAY ready or a software reset request, then re-sequences.
//  Sits directly downstream of the clock/reset infrastructure block; drives all user-logic resets.
// PARAMETERS
//  N_STAGES     4    number of staged reset outputs (1..16)
//  GAP_CYCLES   256  user_clk cycles between successive stage releases (>=2)
//  RDY_FILTER   16   consecutive synced-high cycles of idelay_rdy required before sequencing (>=1)
//  SW_RST_HOLD  64   minimum cycles all stages are held asserted after an abort (>=1)
// PORTS
//  user_clk       in   1         sole clock; all logic on its rising edge
//  sys_rst        in   1         synchronous, active-high reset (top level drives it from sys_clk_rst_sync)
//  idelay_rdy     in   1         IDELAYCTRL ready; asynchronous to user_clk
//  sw_rst_req     in   1         software reset request, single-cycle pulse, user_clk domain
//  rst_out        out  N_STAGES  active-high stage resets; bit 0 released first
//  seq_done       out  1         all stages released (state RUN)
//  abort_count    out  8         saturating count of aborts (RELEASE/RUN -> ASSERT)
// BEHAVIOUR
//  - sys_rst=1: rst_out=all 1s, seq_done=0, abort_count=0, state=HOLD, all counters/filter cleared. Wins over every input.
//  - idelay_rdy: 2-flop synchroniser (ASYNC_REG). Filter counter increments while synced=1, clears on any synced=0;
//    rdy_ok (registered) =1 once counter reaches RDY_FILTER; =0 the cycle after synced goes low.
//  - States (encoding in shared header): HOLD, RELEASE, RUN, ASSERT.
//    HOLD:    rst_out=all 1s. rdy_ok=1 -> RELEASE with idx=0, gap_cnt=0. sw_rst_req ignored.
//    RELEASE: gap_cnt++ each cycle. When gap_cnt==GAP_CYCLES-1: rst_out[idx]<=0, gap_cnt<=0, idx++;
//             if idx==N_STAGES-1 -> RUN, seq_done<=1 same edge. Stage k deasserts (k+1)*GAP_CYCLES cycles after entry.
//    RUN:     outputs static.
//    ASSERT:  entered from RELEASE or RUN when rdy_ok=0 or sw_rst_req=1 (registered: rst_out<=all 1s, seq_done<=0,
//             hold_cnt<=0, abort_count++ saturating at 255). hold_cnt++ each cycle; at SW_RST_HOLD-1 -> HOLD.
//             sw_rst_req and rdy loss in ASSERT ignored (hold_cnt not restarted).
//  - Abort precedence: abort on the same edge as a stage release wins; that stage stays asserted.
//  - Latency: rdy edge -> rdy_ok = 2 sync + RDY_FILTER + 1 cycles; abort -> rst_out all 1s = 1 cycle.
//  - rst_out bits are monotone within a sequence: never deasserted out of index order; never glitch (all registered).
//  - All counters sized $clog2(param+1); no wrap possible (terminal values bounded).
// STRUCTURE
//  - Shared header/package: state encoding localparams (HOLD/RELEASE/RUN/ASSERT), ABORT_CNT_W=8.
//  - One sub-module: htg9200_rdy_filter (2-flop sync + consecutive-high filter, params RDY_FILTER; out rdy_ok).
//  - Top: FSM, gap/hold counters, stage index, rst_out register, abort counter.
// TESTING  (N_STAGES=4, GAP_CYCLES=8, RDY_FILTER=4, SW_RST_HOLD=6)
//  1. sys_rst 5 cycles, idelay_rdy=0 -> rst_out=4'b1111, seq_done=0, abort_count=0, stays so indefinitely.
//  2. idelay_rdy 0->1 steady -> rdy_ok after 2+4+1 cycles; rst_out 1110,1100,1000,0000 at +8,+16,+24,+32 from RELEASE;
//     seq_done=1 with the 0000 edge.
//  3. idelay_rdy glitch high 3 cycles then low -> no release; rst_out=1111; filter restarts from 0.
//  4. In RUN pulse sw_rst_req -> next cycle rst_out=1111, seq_done=0, abort_count=1; 6 cycles later HOLD, re-sequences
//     (rdy still high: rdy_ok already 1 -> RELEASE next cycle).
//  5. Drop idelay_rdy mid-RELEASE after stage 1 released -> rst_out=1111 within 2 sync +1 +1 cycles; remaining stages
//     never release until rdy re-qualifies; abort_count=1; sw_rst_req pulsed in ASSERT leaves hold timing unchanged.
//  6. sys_rst asserted mid-RELEASE with sw_rst_req same cycle -> rst_out=1111, abort_count=0 (reset wins);
//     300 forced aborts -> abort_count saturates at 255.

Source files
------------

// File: rtl/htg9200_rst_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// htg9200_rst_sequencer_pkg
// Shared definitions for the staged reset sequencer: FSM state encoding,
// abort counter width and a small saturating-increment helper.
// ---------------------------------------------------------------------------
package htg9200_rst_sequencer_pkg;

  // State encoding for the sequencer FSM
  localparam logic [1:0] ST_ENC_HOLD    = 2'd0;
  localparam logic [1:0] ST_ENC_RELEASE = 2'd1;
  localparam logic [1:0] ST_ENC_RUN     = 2'd2;
  localparam logic [1:0] ST_ENC_ASSERT  = 2'd3;

  typedef enum logic [1:0] {
    ST_HOLD    = ST_ENC_HOLD,
    ST_RELEASE = ST_ENC_RELEASE,
    ST_RUN     = ST_ENC_RUN,
    ST_ASSERT  = ST_ENC_ASSERT
  } seq_state_t;

  localparam int ABORT_CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [ABORT_CNT_W-1:0] sat_inc_abort(input logic [ABORT_CNT_W-1:0] v);
    return (v == {ABORT_CNT_W{1'b1}}) ? v : v + ABORT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/htg9200_rst_sequencer_rdy_filter.sv
// ---------------------------------------------------------------------------
// htg9200_rdy_filter
// Brings the asynchronous IDELAYCTRL ready into the user_clk domain and only
// reports it as good after it has stayed high for RDY_FILTER consecutive
// synchronised cycles. Any synchronised low drops rdy_ok on the next edge.
// Ports:
//   user_clk    in   sole clock
//   sys_rst     in   synchronous active-high reset
//   idelay_rdy  in   raw IDELAYCTRL ready, asynchronous
//   rdy_ok      out  registered, filtered ready
// ---------------------------------------------------------------------------
module htg9200_rdy_filter
  import htg9200_rst_sequencer_pkg::*;
#(
  parameter int RDY_FILTER = 16
) (
  input  logic user_clk,
  input  logic sys_rst,
  input  logic idelay_rdy,
  output logic rdy_ok
);

  localparam int CNT_W = $clog2(RDY_FILTER + 1);

  (* ASYNC_REG = "TRUE" *) logic rdy_meta;
  (* ASYNC_REG = "TRUE" *) logic rdy_sync;
  logic [CNT_W-1:0]              high_cnt;

  // Two-flop synchroniser for the asynchronous ready input
  always_ff @(posedge user_clk) begin
    if (sys_rst) begin
      rdy_meta <= 1'b0;
      rdy_sync <= 1'b0;
    end else begin
      rdy_meta <= idelay_rdy;
      rdy_sync <= rdy_meta;
    end
  end

  // Consecutive-high counter; parks at RDY_FILTER so it cannot wrap
  always_ff @(posedge user_clk) begin
    if (sys_rst || !rdy_sync) begin
      high_cnt <= '0;
    end else if (high_cnt != CNT_W'(RDY_FILTER)) begin
      high_cnt <= high_cnt + CNT_W'(1);
    end
  end

  // Gating with rdy_sync makes a low drop rdy_ok one edge after it is seen,
  // rather than waiting for the counter to clear first
  always_ff @(posedge user_clk) begin
    if (sys_rst) begin
      rdy_ok <= 1'b0;
    end else begin
      rdy_ok <= rdy_sync && (high_cnt == CNT_W'(RDY_FILTER));
    end
  end

endmodule

// File: rtl/htg9200_rst_sequencer.sv
// ---------------------------------------------------------------------------
// htg9200_rst_sequencer
// Releases N_STAGES user-logic resets in index order, GAP_CYCLES apart, once
// IDELAY ready has qualified. Loss of ready or a software reset request
// re-asserts every stage, holds them for SW_RST_HOLD cycles and re-sequences.
// Ports:
//   user_clk     in   sole clock
//   sys_rst      in   synchronous active-high reset
//   idelay_rdy   in   IDELAYCTRL ready, asynchronous
//   sw_rst_req   in   single-cycle software reset request
//   rst_out      out  active-high stage resets, bit 0 released first
//   seq_done     out  all stages released
//   abort_count  out  saturating number of aborts
// ---------------------------------------------------------------------------
module htg9200_rst_sequencer
  import htg9200_rst_sequencer_pkg::*;
#(
  parameter int N_STAGES    = 4,
  parameter int GAP_CYCLES  = 256,
  parameter int RDY_FILTER  = 16,
  parameter int SW_RST_HOLD = 64
) (
  input  logic                   user_clk,
  input  logic                   sys_rst,
  input  logic                   idelay_rdy,
  input  logic                   sw_rst_req,
  output logic [N_STAGES-1:0]    rst_out,
  output logic                   seq_done,
  output logic [ABORT_CNT_W-1:0] abort_count
);

  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int IDX_W  = $clog2(N_STAGES + 1);
  localparam int HOLD_W = $clog2(SW_RST_HOLD + 1);

  seq_state_t          state;
  seq_state_t          state_nxt;
  logic                rdy_ok;
  logic [GAP_W-1:0]    gap_cnt;
  logic [IDX_W-1:0]    stage_idx;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [N_STAGES-1:0] stage_mask;

  logic abort_req;
  logic gap_done;
  logic last_stage;
  logic hold_done;
  logic start_seq;
  logic do_abort;
  logic do_release;
  logic gap_inc;
  logic hold_inc;

  htg9200_rdy_filter #(
    .RDY_FILTER(RDY_FILTER)
  ) u_rdy_filter (
    .user_clk  (user_clk),
    .sys_rst   (sys_rst),
    .idelay_rdy(idelay_rdy),
    .rdy_ok    (rdy_ok)
  );

  assign abort_req  = !rdy_ok || sw_rst_req;
  assign gap_done   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign last_stage = (stage_idx == IDX_W'(N_STAGES - 1));
  assign hold_done  = (hold_cnt == HOLD_W'(SW_RST_HOLD - 1));

  // One-hot select of the stage currently being released
  always_comb begin
    stage_mask = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      stage_mask[k] = (stage_idx == IDX_W'(k));
    end
  end

  // State register
  always_ff @(posedge user_clk) begin
    if (sys_rst) begin
      state <= ST_HOLD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; an abort is checked before a stage release so the
  // stage due on the same edge stays asserted
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD:    if (rdy_ok) state_nxt = ST_RELEASE;
      ST_RELEASE: begin
        if (abort_req) begin
          state_nxt = ST_ASSERT;
        end else if (gap_done && last_stage) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN:     if (abort_req) state_nxt = ST_ASSERT;
      ST_ASSERT:  if (hold_done) state_nxt = ST_HOLD;
      default:    state_nxt = ST_HOLD;
    endcase
  end

  // Control strobes decoded from the current state for the datapath
  always_comb begin
    start_seq  = (state == ST_HOLD) && rdy_ok;
    do_abort   = ((state == ST_RELEASE) || (state == ST_RUN)) && abort_req;
    do_release = (state == ST_RELEASE) && !abort_req && gap_done;
    gap_inc    = (state == ST_RELEASE) && !abort_req && !gap_done;
    hold_inc   = (state == ST_ASSERT);
  end

  // Counters, stage index and the registered reset outputs
  always_ff @(posedge user_clk) begin
    if (sys_rst) begin
      gap_cnt     <= '0;
      stage_idx   <= '0;
      hold_cnt    <= '0;
      rst_out     <= '1;
      seq_done    <= 1'b0;
      abort_count <= '0;
    end else begin
      if (start_seq) begin
        gap_cnt   <= '0;
        stage_idx <= '0;
      end
      if (gap_inc) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
      if (do_release) begin
        gap_cnt   <= '0;
        stage_idx <= stage_idx + IDX_W'(1);
        rst_out   <= rst_out & ~stage_mask;
        if (last_stage) begin
          seq_done <= 1'b1;
        end
      end
      if (do_abort) begin
        rst_out     <= '1;
        seq_done    <= 1'b0;
        hold_cnt    <= '0;
        abort_count <= sat_inc_abort(abort_count);
      end
      if (hold_inc) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_htg9200_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_htg9200_rst_sequencer
// Drives the sequencer with directed scenarios and random traffic and compares
// every cycle against a timeline model: ready qualifies after R+1 consecutive
// high input samples seen two cycles late; during a sequence the number of
// released stages is the elapsed time divided by the gap.
// ---------------------------------------------------------------------------
module tb_htg9200_rst_sequencer;

  localparam int N    = 4;
  localparam int GAP  = 8;
  localparam int R    = 4;
  localparam int HOLD = 6;

  localparam int P_IDLE = 0;
  localparam int P_SEQ  = 1;
  localparam int P_WAIT = 2;

  logic         user_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic         idelay_rdy = 1'b0;
  logic         sw_rst_req = 1'b0;
  logic [N-1:0] rst_out;
  logic         seq_done;
  logic [7:0]   abort_count;

  int nCompared = 0;
  int nMismatched = 0;

  int         cyc = 0;
  int         c0 = 0, c1 = 0, c2 = 0;
  bit         mOk = 0;
  int         phase = P_IDLE;
  int         seqStart = 0;
  int         holdStart = 0;
  int         mAborts = 0;
  logic [N-1:0] mRst = '1;
  bit         mDone = 0;

  htg9200_rst_sequencer #(
    .N_STAGES   (N),
    .GAP_CYCLES (GAP),
    .RDY_FILTER (R),
    .SW_RST_HOLD(HOLD)
  ) dut (
    .user_clk   (user_clk),
    .sys_rst    (sys_rst),
    .idelay_rdy (idelay_rdy),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_out),
    .seq_done   (seq_done),
    .abort_count(abort_count)
  );

  always #5 user_clk = ~user_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance the model by one rising edge with the inputs applied before it
  task automatic modelStep(input logic rst, input logic rdy, input logic sw);
    int el;
    int prev;
    if (rst) begin
      c0 = 0; c1 = 0; c2 = 0;
      mOk = 0; phase = P_IDLE; mAborts = 0;
      mRst = '1; mDone = 0;
    end else begin
      case (phase)
        P_IDLE: begin
          if (mOk) begin
            phase = P_SEQ;
            seqStart = cyc;
          end
        end
        P_SEQ: begin
          if (!mOk || sw) begin
            phase = P_WAIT;
            holdStart = cyc;
            if (mAborts < 255) mAborts++;
            mRst = '1;
            mDone = 0;
          end else begin
            el = (cyc - seqStart) / GAP;
            if (el > N) el = N;
            mRst = 4'b1111 << el;
            mDone = (el == N);
          end
        end
        default: begin
          if (cyc - holdStart == HOLD) phase = P_IDLE;
        end
      endcase
      prev = c0;
      c2 = c1;
      c1 = c0;
      c0 = rdy ? prev + 1 : 0;
      mOk = (c2 >= R + 1);
    end
    cyc++;
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic sw);
    sys_rst = rst;
    idelay_rdy = rdy;
    sw_rst_req = sw;
    @(posedge user_clk);
    modelStep(rst, rdy, sw);
    @(negedge user_clk);
    checkOutput("rst_out", 32'(rst_out), 32'(mRst));
    checkOutput("seq_done", 32'(seq_done), 32'(mDone));
    checkOutput("abort_count", 32'(abort_count), 32'(mAborts));
  endtask

  initial begin
    int guard;
    bit rdyLevel;
    @(negedge user_clk);

    // Reset with ready low, then stay idle
    repeat (5) applyStimulus(1, 0, 0);
    checkOutput("reset_rst_out", 32'(rst_out), 32'hF);
    checkOutput("reset_abort", 32'(abort_count), 32'd0);
    repeat (40) applyStimulus(0, 0, 0);
    checkOutput("idle_rst_out", 32'(rst_out), 32'hF);

    // Short glitch must not qualify
    repeat (3) applyStimulus(0, 1, 0);
    repeat (15) applyStimulus(0, 0, 0);
    checkOutput("glitch_rst_out", 32'(rst_out), 32'hF);

    // Full sequence with steady ready
    guard = 0;
    while (!mDone && guard < 100) begin
      applyStimulus(0, 1, 0);
      guard++;
    end
    checkOutput("seq_timeout", 32'(guard < 100), 32'd1);
    checkOutput("run_rst_out", 32'(rst_out), 32'h0);
    repeat (10) applyStimulus(0, 1, 0);

    // Software abort from RUN, hold then re-sequence
    applyStimulus(0, 1, 1);
    checkOutput("sw_abort_rst", 32'(rst_out), 32'hF);
    checkOutput("sw_abort_cnt", 32'(abort_count), 32'd1);
    repeat (50) applyStimulus(0, 1, 0);

    // Ready loss after stage 1 released; sw pulse inside the hold
    applyStimulus(1, 1, 0);
    guard = 0;
    while (mRst != 4'b1100 && guard < 100) begin
      applyStimulus(0, 1, 0);
      guard++;
    end
    checkOutput("stage1_timeout", 32'(guard < 100), 32'd1);
    repeat (4) applyStimulus(0, 0, 0);
    checkOutput("drop_rst", 32'(rst_out), 32'hF);
    checkOutput("drop_cnt", 32'(abort_count), 32'd1);
    applyStimulus(0, 0, 1);
    repeat (20) applyStimulus(0, 0, 0);
    repeat (60) applyStimulus(0, 1, 0);

    // Reset during RELEASE together with a sw request
    applyStimulus(1, 1, 0);
    repeat (15) applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 1);
    checkOutput("rst_wins_rst", 32'(rst_out), 32'hF);
    checkOutput("rst_wins_cnt", 32'(abort_count), 32'd0);

    // Random traffic
    rdyLevel = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(59) == 0) rdyLevel = ~rdyLevel;
      applyStimulus($urandom_range(499) == 0, rdyLevel, $urandom_range(79) == 0);
    end

    // Force 300 aborts to hit saturation
    applyStimulus(1, 1, 0);
    for (int a = 0; a < 300; a++) begin
      guard = 0;
      while (phase != P_SEQ && guard < 40) begin
        applyStimulus(0, 1, 0);
        guard++;
      end
      applyStimulus(0, 1, 1);
    end
    checkOutput("abort_sat", 32'(abort_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
